// File: rtl/module_countdown_timer.sv
// ============================================================================
// Module      : module_countdown_timer
// Description : Loadable, pausable down-counter with prescaled tick and done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module module_countdown_timer #(
  parameter int PRESCALE = 10,
  parameter int WIDTH    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             zero_o
);

  // A prescaler of one cycle still needs a 1-bit register to stay legal.
  localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [PW-1:0]    presc, presc_n;
  logic [WIDTH-1:0] count_n;
  logic             done_n;
  logic             busy_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      presc   <= '0;
      count_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      count_o <= count_n;
      busy_o  <= busy_n;
      done_o  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    count_n = count_o;
    done_n  = 1'b0;
    if (load_i) begin
      state_n = ST_IDLE;
      presc_n = '0;
      count_n = load_val_i;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i && (count_o != '0)) begin
            state_n = ST_RUN;
            presc_n = '0;
          end
        end
        ST_RUN: begin
          if (pause_i) begin
            state_n = ST_PAUSE;
          end else if (presc == PRESC_LAST) begin
            presc_n = '0;
            if (count_o != '0) begin
              count_n = count_o - WIDTH'(1);
            end
            // Reaching zero ends the run on the same edge as the pulse.
            if (count_o == WIDTH'(1)) begin
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (start_i) begin
            state_n = ST_RUN;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
    busy_n = (state_n != ST_IDLE);
  end

  assign zero_o = (count_o == '0);

endmodule

`default_nettype wire

// File: tb/tb_module_countdown_timer.sv
// ============================================================================
// Module      : tb_module_countdown_timer
// Description : Directed self-checking bench for module_countdown_timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_module_countdown_timer;

  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_i, start_i, pause_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] count_o;
  logic             busy_o, done_o, zero_o;

  logic             load1_i, start1_i, pause1_i;
  logic [WIDTH-1:0] load_val1_i;
  logic [WIDTH-1:0] count1_o;
  logic             busy1_o, done1_o, zero1_o;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  module_countdown_timer #(.PRESCALE(10), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .load_i(load_i), .load_val_i(load_val_i),
    .start_i(start_i), .pause_i(pause_i), .count_o(count_o),
    .busy_o(busy_o), .done_o(done_o), .zero_o(zero_o)
  );

  module_countdown_timer #(.PRESCALE(1), .WIDTH(WIDTH)) dut_p1 (
    .clk(clk), .rst(rst), .load_i(load1_i), .load_val_i(load_val1_i),
    .start_i(start1_i), .pause_i(pause1_i), .count_o(count1_o),
    .busy_o(busy1_o), .done_o(done1_o), .zero_o(zero1_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n edges; inputs change and outputs are sampled 1 ns after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_val(input logic [WIDTH-1:0] v);
    load_val_i = v;
    load_i     = 1'b1;
    step(1);
    load_i     = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    load_i = 1'b0; start_i = 1'b0; pause_i = 1'b0; load_val_i = '0;
    load1_i = 1'b0; start1_i = 1'b0; pause1_i = 1'b0; load_val1_i = '0;

    step(2);
    check_val("rst_count", 32'(count_o), 0);
    check_val("rst_busy",  32'(busy_o),  0);
    check_val("rst_done",  32'(done_o),  0);
    check_val("rst_zero",  32'(zero_o),  1);
    rst = 1'b1;

    // Full countdown from 5
    load_val(6'd5);
    check_val("ld5_count", 32'(count_o), 5);
    pulse_start();
    check_val("run_busy", 32'(busy_o), 1);
    step(9);
    check_val("pre_tick_count", 32'(count_o), 5);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check_val("tick_count", 32'(count_o), 32'(5 - k));
      check_val("tick_done",  32'(done_o),  (k == 5) ? 1 : 0);
      check_val("tick_busy",  32'(busy_o),  (k == 5) ? 0 : 1);
      if (k < 5) step(9);
    end
    check_val("end_zero", 32'(zero_o), 1);
    step(1);
    check_val("done_pulse_end", 32'(done_o), 0);
    check_val("hold_zero",      32'(count_o), 0);

    // Pause and resume
    load_val(6'd5);
    pulse_start();
    step(25);
    check_val("pre_pause_count", 32'(count_o), 3);
    pause_i = 1'b1;
    step(1);
    pause_i = 1'b0;
    step(40);
    check_val("paused_count", 32'(count_o), 3);
    check_val("paused_busy",  32'(busy_o),  1);
    pulse_start();
    step(4);
    check_val("resume_hold", 32'(count_o), 3);
    step(1);
    check_val("resume_tick", 32'(count_o), 2);

    // Load aborts a run
    load_val(6'd5);
    pulse_start();
    step(15);
    check_val("abort_pre", 32'(count_o), 4);
    load_val(6'd63);
    check_val("abort_count", 32'(count_o), 63);
    check_val("abort_busy",  32'(busy_o),  0);
    check_val("abort_done",  32'(done_o),  0);
    step(20);
    check_val("abort_idle_count", 32'(count_o), 63);

    // Start with count 0 is ignored
    load_val(6'd0);
    pulse_start();
    check_val("zstart_busy", 32'(busy_o), 0);
    check_val("zstart_done", 32'(done_o), 0);
    step(5);
    check_val("zstart_count", 32'(count_o), 0);

    // Reset mid-run
    load_val(6'd5);
    pulse_start();
    step(11);
    check_val("midrst_pre", 32'(count_o), 4);
    rst = 1'b0;
    step(1);
    check_val("midrst_count", 32'(count_o), 0);
    check_val("midrst_busy",  32'(busy_o),  0);
    check_val("midrst_done",  32'(done_o),  0);
    rst = 1'b1;
    step(15);
    check_val("midrst_idle", 32'(busy_o), 0);

    // PRESCALE=1 instance
    load_val1_i = 6'd2;
    load1_i = 1'b1;
    step(1);
    load1_i = 1'b0;
    start1_i = 1'b1;
    step(1);
    start1_i = 1'b0;
    step(1);
    check_val("p1_count1", 32'(count1_o), 1);
    check_val("p1_done1",  32'(done1_o),  0);
    step(1);
    check_val("p1_count0", 32'(count1_o), 0);
    check_val("p1_done0",  32'(done1_o),  1);
    check_val("p1_busy0",  32'(busy1_o),  0);
    step(1);
    check_val("p1_done_end", 32'(done1_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
